// File: rtl/bm_seq_mult_pkg.sv
// Shared encodings for the sequential multiply / logic benchmark unit.
package bm_seq_mult_pkg;

    localparam logic [1:0] MODE_MUL = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_OR  = 2'b10;
    localparam logic [1:0] MODE_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bm_shift_add_core.sv
// Shift-add multiplier datapath: one multiplier bit per step, LSB first.
module bm_shift_add_core #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               last_bit
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [CNT_W-1:0]   cnt;

    // acc_next already includes the current bit so the final sum is
    // available on the same edge that retires the last bit.
    always_comb begin
        addend = '0;
        if (b[cnt]) begin
            addend = {{WIDTH{1'b0}}, a} << cnt;
        end
        acc_next = acc + addend;
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clock) begin
        if (reset || start) begin
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bm_seq_mult_logic.sv
// Multi-cycle multiply / single-cycle logic unit with valid/ready on
// both sides; DONE can accept the next transaction back-to-back.
module bm_seq_mult_logic
    import bm_seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               accept;
    logic               start;
    logic               step;
    logic               last_bit;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] logic_res;

    assign in_ready  = !reset &&
                       (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign start     = accept && (mode == MODE_MUL);
    assign step      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

    always_comb begin
        logic_res = '0;
        unique case (mode)
            MODE_AND: logic_res = {{WIDTH{1'b0}}, a_in & b_in};
            MODE_OR:  logic_res = {{WIDTH{1'b0}}, a_in | b_in};
            MODE_XOR: logic_res = {{WIDTH{1'b0}}, a_in ^ b_in};
            default:  logic_res = '0;
        endcase
    end

    bm_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .step     (step),
        .a        (a_q),
        .b        (b_q),
        .acc_next (acc_next),
        .last_bit (last_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (accept) begin
            a_q <= a_in;
            b_q <= b_in;
            if (mode == MODE_MUL) begin
                state <= BUSY;
            end else begin
                result <= logic_res;
                state  <= DONE;
            end
        end else begin
            case (state)
                BUSY: begin
                    if (last_bit) begin
                        result <= acc_next;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bm_seq_mult_logic.sv
// Directed-vector bench for bm_seq_mult_logic (WIDTH=8 plus a WIDTH=16 build).
module tb_bm_seq_mult_logic;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [1:0]  mode      = 2'b00;
    logic [7:0]  a_in      = '0;
    logic [7:0]  b_in      = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        busy;

    logic        in_valid_w  = 1'b0;
    logic        in_ready_w;
    logic [1:0]  mode_w      = 2'b00;
    logic [15:0] a_w         = '0;
    logic [15:0] b_w         = '0;
    logic        out_valid_w;
    logic        out_ready_w = 1'b0;
    logic [31:0] result_w;
    logic        busy_w;

    int nvec  = 0;
    int nfail = 0;

    always #5 clock = ~clock;

    bm_seq_mult_logic #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    bm_seq_mult_logic #(.WIDTH(16)) dut16 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid_w),
        .in_ready  (in_ready_w),
        .mode      (mode_w),
        .a_in      (a_w),
        .b_in      (b_w),
        .out_valid (out_valid_w),
        .out_ready (out_ready_w),
        .result    (result_w),
        .busy      (busy_w)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int busy_n;
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            tick();
            guard++;
        end
        check($sformatf("v%0d_ready", idx), in_ready, 1);
        in_valid  = 1'b1;
        mode      = v.mode;
        a_in      = v.a;
        b_in      = v.b;
        out_ready = 1'b1;
        tick();
        // scramble inputs after accept; they must be ignored
        in_valid = 1'b0;
        mode     = ~v.mode;
        a_in     = ~v.a;
        b_in     = ~v.b;
        lat      = 0;
        busy_n   = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_n++;
            tick();
            lat++;
        end
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_result", idx), result, v.exp);
        check($sformatf("v%0d_busy_cycles", idx), busy_n, v.lat);
        tick();
        check($sformatf("v%0d_back_idle", idx), out_valid, 0);
    endtask

    initial begin
        int guard;
        int stale;
        int lat;

        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_result_w16", result_w, 0);
        reset = 1'b0;
        #1;
        check("rst_release_ready", in_ready, 1);

        vecs[0]  = '{2'b00, 8'hFF, 8'hFF, 16'hFE01, 8};
        vecs[1]  = '{2'b00, 8'h00, 8'hA5, 16'h0000, 8};
        vecs[2]  = '{2'b00, 8'd13, 8'd11, 16'd143,  8};
        vecs[3]  = '{2'b00, 8'h01, 8'h01, 16'h0001, 8};
        vecs[4]  = '{2'b00, 8'hA5, 8'h00, 16'h0000, 8};
        vecs[5]  = '{2'b00, 8'h80, 8'h80, 16'h4000, 8};
        vecs[6]  = '{2'b00, 8'd200, 8'd3, 16'd600,  8};
        vecs[7]  = '{2'b01, 8'hF0, 8'h3C, 16'h0030, 0};
        vecs[8]  = '{2'b10, 8'hF0, 8'h3C, 16'h00FC, 0};
        vecs[9]  = '{2'b11, 8'hF0, 8'h3C, 16'h00CC, 0};
        vecs[10] = '{2'b01, 8'hFF, 8'hFF, 16'h00FF, 0};
        vecs[11] = '{2'b11, 8'hAA, 8'h55, 16'h00FF, 0};

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // back-to-back logic transactions
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_in      = 8'hF0;
        b_in      = 8'h3C;
        mode      = 2'b01;
        #1;
        check("b2b_ready0", in_ready, 1);
        tick();
        check("b2b_valid_and", out_valid, 1);
        check("b2b_and", result, 16'h0030);
        check("b2b_ready1", in_ready, 1);
        mode = 2'b10;
        tick();
        check("b2b_or", result, 16'h00FC);
        check("b2b_ready2", in_ready, 1);
        mode = 2'b11;
        tick();
        check("b2b_xor", result, 16'h00CC);
        check("b2b_valid_xor", out_valid, 1);
        in_valid = 1'b0;
        tick();
        check("b2b_idle", out_valid, 0);

        // backpressure on a multiply result
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'b00;
        a_in      = 8'd13;
        b_in      = 8'd11;
        tick();
        in_valid = 1'b0;
        guard    = 0;
        while (!out_valid && guard < 40) begin
            tick();
            guard++;
        end
        check("bp_valid_arrives", out_valid, 1);
        check("bp_result", result, 16'd143);
        in_valid = 1'b1;
        mode     = 2'b01;
        a_in     = 8'hFF;
        b_in     = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
            check($sformatf("bp_hold_result%0d", i), result, 16'd143);
            check($sformatf("bp_hold_ready%0d", i), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_next_valid", out_valid, 1);
        check("bp_next_result", result, 16'h000F);
        in_valid = 1'b0;
        tick();
        check("bp_idle", out_valid, 0);

        // reset in the middle of a multiply
        in_valid = 1'b1;
        mode     = 2'b00;
        a_in     = 8'hFF;
        b_in     = 8'hFF;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_result", result, 0);
        check("mid_busy_clr", busy, 0);
        check("mid_in_ready", in_ready, 1);
        stale = 0;
        repeat (12) begin
            tick();
            if (out_valid) stale++;
        end
        check("mid_no_stale", stale, 0);

        // WIDTH=16 build
        in_valid_w  = 1'b1;
        out_ready_w = 1'b1;
        mode_w      = 2'b00;
        a_w         = 16'hFFFF;
        b_w         = 16'h0002;
        tick();
        in_valid_w = 1'b0;
        lat        = 0;
        while (!out_valid_w && lat < 60) begin
            tick();
            lat++;
        end
        check("w16_latency", lat, 16);
        check("w16_result", result_w, 32'h0001FFFE);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
